// File: rtl/bbq_op_scheduler.sv
// Enqueue FIFO + dequeue handshake front-end driving the BBQ two-port router.
// Optional `BBQ_SCHED_BYPASS_EN: an enqueue into an empty FIFO issues in the same cycle.
package bbq_sched_pkg;
    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_DEQ_MIN = 2'd1,
        OP_DEQ_MAX = 2'd2,
        OP_DEQ_ANY = 2'd3
    } heap_op_t;
endpackage

module bbq_op_scheduler
    import bbq_sched_pkg::*;
#(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned PRIOR_WIDTH = 6,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned CAPACITY    = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              heap_ready,
    input  logic                              enq_valid,
    output logic                              enq_ready,
    input  logic [DWIDTH-1:0]                 enq_data,
    input  logic [PRIOR_WIDTH-1:0]            enq_prior,
    input  logic                              deq_valid,
    output logic                              deq_ready,
    input  heap_op_t                          deq_op,
    output logic                              sched_rdy,
    output logic                              sched_enque_en,
    output logic [DWIDTH-1:0]                 sched_data,
    output logic [PRIOR_WIDTH-1:0]            sched_prior,
    output logic                              sched_ctrl,
    output heap_op_t                          sched_op,
    output logic [$clog2(CAPACITY+1)-1:0]     heap_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(CAPACITY + 1);
    localparam logic [CW-1:0] CAP_C = CW'(CAPACITY);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FULL_HOLD} state_t;
    state_t state, state_nx;

    logic [DWIDTH-1:0]      mem_data  [FIFO_DEPTH];
    logic [PRIOR_WIDTH-1:0] mem_prior [FIFO_DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr;
    logic                   fifo_empty, fifo_full;
    logic                   push, pop, bypass, head_valid;
    logic                   enq_ok, deq_go, issue;
    logic [DWIDTH-1:0]      head_data;
    logic [PRIOR_WIDTH-1:0] head_prior;
    logic [CW-1:0]          count;
    logic                   deq_shown;

    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        enq_ready  = !fifo_full;
        deq_go     = heap_ready && deq_valid && (count != '0);
        deq_ready  = deq_go;
`ifdef BBQ_SCHED_BYPASS_EN
        bypass     = fifo_empty && enq_valid;
`else
        bypass     = 1'b0;
`endif
        head_valid = !fifo_empty || bypass;
        head_data  = bypass ? enq_data  : mem_data[rd_ptr[AW-1:0]];
        head_prior = bypass ? enq_prior : mem_prior[rd_ptr[AW-1:0]];
        // A full heap still takes an enqueue when a dequeue frees a slot in the same pair.
        enq_ok     = heap_ready && head_valid && ((count < CAP_C) || deq_go);
        issue      = enq_ok || deq_go;
        push       = enq_valid && !fifo_full && !(bypass && enq_ok);
        pop        = enq_ok && !bypass;
    end

    always_comb begin
        state_nx = state;
        if (heap_ready) begin
            if (issue)
                state_nx = S_ISSUE;
            else if (!fifo_empty && (count == CAP_C) && !deq_valid)
                state_nx = S_FULL_HOLD;
            else
                state_nx = S_IDLE;
        end else if (state == S_ISSUE) begin
            state_nx = S_IDLE;
        end
    end

    assign sched_rdy  = (state == S_ISSUE);
    assign heap_count = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr[AW-1:0]]  <= enq_data;
            mem_prior[wr_ptr[AW-1:0]] <= enq_prior;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            sched_enque_en <= 1'b0;
            sched_data     <= '0;
            sched_prior    <= '0;
            sched_op       <= OP_NOP;
            sched_ctrl     <= 1'b0;
            deq_shown      <= 1'b0;
        end else begin
            state <= state_nx;
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            unique case ({enq_ok, deq_go})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            sched_enque_en <= enq_ok;
            sched_data     <= enq_ok ? head_data  : '0;
            sched_prior    <= enq_ok ? head_prior : '0;
            sched_op       <= issue  ? deq_op     : OP_NOP;
            // Selector flips once the router cycle carrying a dequeue has been presented.
            deq_shown      <= deq_go;
            if (deq_shown)
                sched_ctrl <= ~sched_ctrl;
        end
    end

endmodule

// File: tb/tb_bbq_op_scheduler.sv
// Directed + random bench for bbq_op_scheduler against a queue-based occupancy model.
module tb_bbq_op_scheduler;
    import bbq_sched_pkg::*;

    localparam int DW    = 16;
    localparam int PW    = 6;
    localparam int DEPTH = 4;
    localparam int CAP   = 4;

    logic          clk, rst, heap_ready, enq_valid, enq_ready, deq_valid, deq_ready;
    logic [DW-1:0] enq_data, sched_data;
    logic [PW-1:0] enq_prior, sched_prior;
    heap_op_t      deq_op, sched_op;
    logic          sched_rdy, sched_enque_en, sched_ctrl;
    logic [2:0]    heap_count;

    bbq_op_scheduler #(.DWIDTH(DW), .PRIOR_WIDTH(PW), .FIFO_DEPTH(DEPTH), .CAPACITY(CAP)) dut (
        .clk(clk), .rst(rst), .heap_ready(heap_ready),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data), .enq_prior(enq_prior),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_op(deq_op),
        .sched_rdy(sched_rdy), .sched_enque_en(sched_enque_en), .sched_data(sched_data),
        .sched_prior(sched_prior), .sched_ctrl(sched_ctrl), .sched_op(sched_op),
        .heap_count(heap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [PW-1:0] p;
    } ent_t;

    ent_t     q[$];
    int       m_count, m_deq_passed;
    bit       m_last_deq;
    bit       x_rdy, x_en;
    ent_t     x_ent;
    heap_op_t x_op;
    int       total, bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_count = 0; m_deq_passed = 0; m_last_deq = 0;
        x_rdy = 0; x_en = 0; x_ent = '0; x_op = OP_NOP;
    endtask

    task automatic check_outputs();
        chk("sched_rdy",   32'(sched_rdy),      32'(x_rdy));
        chk("enque_en",    32'(sched_enque_en), 32'(x_en));
        chk("sched_data",  32'(sched_data),     32'(x_ent.d));
        chk("sched_prior", 32'(sched_prior),    32'(x_ent.p));
        chk("sched_op",    32'(sched_op),       32'(x_op));
        chk("sched_ctrl",  32'(sched_ctrl),     32'(m_deq_passed % 2));
        chk("heap_count",  32'(heap_count),     32'(m_count));
    endtask

    // Entry and exit at posedge+1: drive, check handshake, advance model, clock, check outputs.
    task automatic cycle(input bit hr, input bit ev, input logic [DW-1:0] ed, input logic [PW-1:0] ep,
                         input bit dv, input heap_op_t op);
        bit   deq_go, enq_ok, byp, accept, avail;
        ent_t head;
        heap_ready = hr; enq_valid = ev; enq_data = ed; enq_prior = ep; deq_valid = dv; deq_op = op;
        #1;
        chk("enq_ready", 32'(enq_ready), 32'(q.size() < DEPTH));
        deq_go = hr && dv && (m_count > 0);
        chk("deq_ready", 32'(deq_ready), 32'(deq_go));
`ifdef BBQ_SCHED_BYPASS_EN
        byp = (q.size() == 0) && ev;
`else
        byp = 0;
`endif
        avail  = (q.size() > 0) || byp;
        enq_ok = hr && avail && ((m_count < CAP) || deq_go);
        accept = ev && (q.size() < DEPTH) && !(byp && enq_ok);
        head   = '0;
        if (enq_ok) head = byp ? ent_t'({ed, ep}) : q.pop_front();
        if (accept) q.push_back(ent_t'({ed, ep}));
        m_count = m_count + (enq_ok ? 1 : 0) - (deq_go ? 1 : 0);
        if (m_last_deq) m_deq_passed++;
        m_last_deq = deq_go;
        x_rdy = enq_ok || deq_go;
        x_en  = enq_ok;
        x_ent = head;
        x_op  = x_rdy ? op : OP_NOP;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b0; heap_ready = 0; enq_valid = 0; enq_data = '0; enq_prior = '0;
        deq_valid = 0; deq_op = OP_NOP;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        chk("rst_enq_ready", 32'(enq_ready), 32'd1);
        chk("rst_deq_ready", 32'(deq_ready), 32'd0);
        rst = 1'b1;

        // single enqueue reaches the router two cycles later
        cycle(1, 1, 16'h00A5, 6'd3, 0, OP_NOP);
        cycle(1, 0, '0, '0, 0, OP_NOP);
        cycle(1, 0, '0, '0, 0, OP_NOP);

        // two more, then three dequeues and one against an empty heap
        cycle(1, 1, 16'h0011, 6'd1, 0, OP_NOP);
        cycle(1, 1, 16'h0022, 6'd2, 0, OP_NOP);
        cycle(1, 0, '0, '0, 0, OP_NOP);
        cycle(1, 0, '0, '0, 0, OP_NOP);
        for (int i = 0; i < 4; i++) cycle(1, 0, '0, '0, 1, OP_DEQ_MIN);
        cycle(1, 0, '0, '0, 0, OP_NOP);

        // fill to capacity, then hold an extra enqueue until a dequeue pairs with it
        for (int i = 0; i < 4; i++) cycle(1, 1, 16'h0100 + 16'(i), 6'(i), 0, OP_NOP);
        cycle(1, 0, '0, '0, 0, OP_NOP);
        cycle(1, 1, 16'h0BEE, 6'd9, 0, OP_NOP);
        for (int i = 0; i < 3; i++) cycle(1, 0, '0, '0, 0, OP_NOP);
        cycle(1, 0, '0, '0, 1, OP_DEQ_MAX);
        cycle(1, 0, '0, '0, 0, OP_NOP);

        // drain, then frozen FIFO fill with overflow attempt and in-order release
        for (int i = 0; i < 4; i++) cycle(1, 0, '0, '0, 1, OP_DEQ_ANY);
        for (int i = 0; i < 5; i++) cycle(0, 1, 16'h0200 + 16'(i), 6'(i + 10), 0, OP_NOP);
        for (int i = 0; i < 5; i++) cycle(1, 0, '0, '0, 0, OP_NOP);

        // leave three entries buffered with an issue in flight, then reset asynchronously
        for (int i = 0; i < 4; i++) cycle(0, 1, 16'h0300 + 16'(i), 6'(i + 20), 0, OP_NOP);
        cycle(1, 0, '0, '0, 1, OP_DEQ_MIN);
        heap_ready = 0; enq_valid = 0; deq_valid = 1; deq_op = OP_DEQ_MIN;
        rst = 1'b0;
        #1;
        m_reset();
        check_outputs();
        chk("arst_enq_ready", 32'(enq_ready), 32'd1);
        chk("arst_deq_ready", 32'(deq_ready), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        deq_valid = 0; deq_op = OP_NOP;
        cycle(1, 0, '0, '0, 1, OP_DEQ_MIN);
        cycle(1, 1, 16'h0444, 6'd4, 0, OP_NOP);
        cycle(1, 0, '0, '0, 0, OP_NOP);
        cycle(1, 0, '0, '0, 0, OP_NOP);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bit       hr, ev, dv;
            heap_op_t op;
            hr = ($urandom_range(0, 3) != 0);
            ev = ($urandom_range(0, 1) != 0);
            dv = ($urandom_range(0, 2) == 0);
            op = dv ? heap_op_t'($urandom_range(1, 3)) : OP_NOP;
            cycle(hr, ev, DW'($urandom), PW'($urandom), dv, op);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
